// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for a Harris corner detector. Each start pulse arms capture of one frame.
// Pixel coordinates are delayed to line up with the detector response, and accepted corners are queued.
module harris_frame_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               vga_blank_n,
    input  logic               vga_vs_n,
    input  logic [7:0]         scale_in,
    input  logic signed [51:0] threshold,
    input  logic signed [51:0] feature,
    output logic               det_shift_en,
    output logic [7:0]         scale_out,
    output logic               corner_valid,
    input  logic               corner_ready,
    output logic [9:0]         corner_x,
    output logic [8:0]         corner_y,
    output logic [7:0]         corner_count,
    output logic               busy,
    output logic               done,
    output logic               overflow
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(LATENCY + 1);

    typedef enum logic [2:0] { IDLE, ARM, ACTIVE, DRAIN, DONE } state_e;

    typedef struct packed {
        logic          en;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } tap_t;

    state_e        state_q, state_d;
    logic          blank_q, vs_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [DW-1:0] drain_q;
    tap_t          pipe_q [LATENCY];
    logic [7:0]    scale_q, count_q;
    logic          ovf_q;
    logic [18:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;

    logic blank_fall, vs_fall, arm_entry, in_active, advance;
    logic cand, full, empty, push, pop;
    tap_t tap;
    logic [9:0] cand_x;
    logic [8:0] cand_y;

    assign blank_fall = blank_q & ~vga_blank_n;
    assign vs_fall    = vs_q & ~vga_vs_n;
    assign arm_entry  = (state_q == IDLE) && start;
    assign in_active  = (state_q == ACTIVE);
    assign advance    = in_active || (state_q == DRAIN);

    assign det_shift_en = in_active && vga_blank_n && (x_q < XW'(H_ACTIVE));

    // NOTE: every path assigns state_d first, so the combinational block can never hold a value (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     if (vs_fall) state_d = ACTIVE;
            ACTIVE:  if (blank_fall && (y_q == YW'(V_ACTIVE - 1))) state_d = DRAIN;
            DRAIN:   if (drain_q == DW'(LATENCY - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window centre sits two pixels behind the newest pixel in both directions.
    assign tap    = pipe_q[LATENCY-1];
    assign cand   = advance && tap.en && (tap.x >= XW'(4)) && (tap.y >= YW'(4))
                    && (feature > threshold);
    assign cand_x = 10'(tap.x) - 10'd2;
    assign cand_y = 9'(tap.y) - 9'd2;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && corner_ready;
    assign push  = cand && (!full || pop);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            blank_q  <= 1'b0;
            vs_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            drain_q  <= '0;
            scale_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= vga_blank_n;
            vs_q    <= vga_vs_n;

            if (arm_entry) begin
                x_q <= '0;
                y_q <= '0;
            end else if (in_active) begin
                if (vga_blank_n) begin
                    if (x_q < XW'(H_ACTIVE)) x_q <= x_q + XW'(1);
                end else if (blank_fall) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end
            end

            drain_q <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;

            if (advance) begin
                pipe_q[0] <= '{en: det_shift_en, x: x_q, y: y_q};
                for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end

            if (arm_entry) begin
                scale_q <= scale_in;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (cand && (count_q != 8'hFF)) count_q <= count_q + 8'd1;
                if (cand && full && !pop) ovf_q <= 1'b1;
            end

            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; emptying the FIFO only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cand_x, cand_y};
    end

    assign {corner_x, corner_y} = mem_q[rd_ptr_q[AW-1:0]];
    assign corner_valid = !empty;
    assign corner_count = count_q;
    assign scale_out    = scale_q;
    assign overflow     = ovf_q;
    assign busy         = (state_q == ARM) || advance;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Directed bench for harris_frame_ctrl on a reduced 120x56 frame.
// Corner tables select which pixels get a feature above threshold.
module tb_harris_frame_ctrl;
    localparam int H = 120, V = 56, L = 4, DEPTH = 16, LINE_LEN = 136, HBLANK = 8;

    logic clk = 1'b0;
    logic reset, start, vga_blank_n, vga_vs_n, corner_ready;
    logic [7:0] scale_in, scale_out, corner_count;
    logic signed [51:0] threshold, feature;
    logic det_shift_en, corner_valid, busy, done, overflow;
    logic [9:0] corner_x;
    logic [8:0] corner_y;

    harris_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .LATENCY(L), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .vga_blank_n(vga_blank_n),
        .vga_vs_n(vga_vs_n), .scale_in(scale_in), .threshold(threshold), .feature(feature),
        .det_shift_en(det_shift_en), .scale_out(scale_out), .corner_valid(corner_valid),
        .corner_ready(corner_ready), .corner_x(corner_x), .corner_y(corner_y),
        .corner_count(corner_count), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { bit en; int col; int row; } pix_t;
    typedef struct { int px; int py; bit valid; bit pulse; } cand_t;

    cand_t tbl[$];
    pix_t  hist[$];
    int    got_x[$], got_y[$];
    logic signed [51:0] hi_v, lo_v;
    bit noisy = 0, ready_mode = 0, cv_seen = 0, busy_seen = 0;
    int n_checks = 0, n_pass = 0, cyc = 0, shift_cnt = 0, line_shift = 0, lines_bad = 0;
    int done_cnt = 0, done_cyc = 0, fall_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: the feature follows the pixel that was shifted L cycles earlier.
    task automatic cycle(input logic blank, input logic vs, input logic st,
                         input bit en, input int col, input int row);
        pix_t e, d;
        bit sel, pulse;
        e.en = en; e.col = col; e.row = row;
        d = hist.pop_front();
        hist.push_back(e);
        sel = 0; pulse = 0;
        if (d.en)
            foreach (tbl[i])
                if (tbl[i].px == d.col && tbl[i].py == d.row) begin
                    sel = 1;
                    pulse = tbl[i].pulse;
                end
        vga_blank_n  = blank;
        vga_vs_n     = vs;
        start        = st;
        feature      = (d.en ? sel : noisy) ? hi_v : lo_v;
        corner_ready = ready_mode | pulse;
        @(negedge clk);
        if (det_shift_en) begin shift_cnt++; line_shift++; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (corner_valid) cv_seen = 1;
        if (busy) busy_seen = 1;
        if (corner_valid && corner_ready) begin
            got_x.push_back(int'(corner_x));
            got_y.push_back(int'(corner_y));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic vs);
        repeat (n) cycle(1'b0, vs, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_frame(input logic [7:0] sc, input int abort_row);
        shift_cnt = 0; lines_bad = 0; cv_seen = 0;
        got_x.delete(); got_y.delete();
        idle(3, 1'b1);
        scale_in = sc;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        scale_in = ~sc;
        idle(2, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        idle(2, 1'b1);
        idle(3, 1'b0);
        idle(3, 1'b1);
        for (int r = 0; r < V; r++) begin
            line_shift = 0;
            for (int c = 0; c < LINE_LEN; c++)
                cycle(1'b1, 1'b1, (r == 30 && c == 5), c < H, c, r);
            if (line_shift != H) lines_bad++;
            if (r == abort_row) return;
            fall_cyc = cyc;
            idle(HBLANK, 1'b1);
        end
        idle(20, 1'b1);
    endtask

    task automatic check_pops(input string tag, input int skip, input int n);
        int k = 0;
        int j = 0;
        check({tag, "_pop_count"}, got_x.size(), n);
        foreach (tbl[i])
            if (tbl[i].valid) begin
                if (k >= skip && j < n && j < got_x.size()) begin
                    check($sformatf("%s_x%0d", tag, j), got_x[j], tbl[i].px - 2);
                    check($sformatf("%s_y%0d", tag, j), got_y[j], tbl[i].py - 2);
                    j++;
                end
                k++;
            end
    endtask

    task automatic drain();
        got_x.delete(); got_y.delete();
        ready_mode = 1;
        idle(40, 1'b1);
        ready_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, hx, hy, changes;
        reset = 1'b0; start = 1'b0; vga_blank_n = 1'b0; vga_vs_n = 1'b1;
        scale_in = 8'h00; threshold = '0; feature = '0; corner_ready = 1'b0;
        hi_v = '0; lo_v = '0;
        for (int i = 0; i < L; i++) hist.push_back('{1'b0, 0, 0});
        @(posedge clk); #1;

        // Reset, with a start pulse and scale that reset must override.
        scale_in = 8'h5A;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        idle(3, 1'b1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", corner_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", corner_count, 0);
        check("rst_scale", scale_out, 0);
        check("rst_shift_en", det_shift_en, 0);
        reset = 1'b1;
        idle(2, 1'b1);
        check("idle_busy", busy, 0);

        // Frame 1: threshold equals every feature, so nothing may qualify.
        threshold = 52'sh7FFFFFFFFFFFF; hi_v = threshold; lo_v = threshold;
        tbl.delete(); noisy = 0;
        d0 = done_cnt;
        run_frame(8'h21, -1);
        check("f1_shift_cycles", shift_cnt, 6720);
        check("f1_lines_bad", lines_bad, 0);
        check("f1_done_pulses", done_cnt - d0, 1);
        check("f1_done_latency", done_cyc - fall_cyc, 5);
        check("f1_count", corner_count, 0);
        check("f1_valid_seen", cv_seen, 0);
        check("f1_busy_end", busy, 0);
        check("f1_scale", scale_out, 8'h21);

        // Frame 2: single negative-threshold corner at (100,50), consumer always ready.
        threshold = -52'sd5; hi_v = -52'sd4; lo_v = -52'sd5;
        tbl.delete();
        tbl.push_back('{100, 50, 1'b1, 1'b0});
        ready_mode = 1;
        d0 = done_cnt;
        run_frame(8'h22, -1);
        ready_mode = 0;
        check("f2_pops", got_x.size(), 1);
        check("f2_x", got_x.size() > 0 ? got_x[0] : -1, 98);
        check("f2_y", got_y.size() > 0 ? got_y[0] : -1, 48);
        check("f2_count", corner_count, 1);
        check("f2_overflow", overflow, 0);
        check("f2_valid_end", corner_valid, 0);
        check("f2_done_pulses", done_cnt - d0, 1);

        // Frame 3: 21 qualifying corners plus border pixels and noisy unshifted cycles.
        threshold = 52'sd1000; hi_v = 52'sd1001; lo_v = 52'sd1000;
        noisy = 1;
        tbl.delete();
        tbl.push_back('{2, 1, 1'b0, 1'b0});
        tbl.push_back('{50, 2, 1'b0, 1'b0});
        for (int r = 4; r <= 10; r++) begin
            tbl.push_back('{4, r, 1'b1, 1'b0});
            tbl.push_back('{60, r, 1'b1, 1'b0});
            tbl.push_back('{119, r, 1'b1, 1'b0});
        end
        tbl.push_back('{3, 20, 1'b0, 1'b0});
        tbl.push_back('{0, 30, 1'b0, 1'b0});
        run_frame(8'h33, -1);
        noisy = 0;
        check("f3_count", corner_count, 21);
        check("f3_overflow", overflow, 1);
        check("f3_valid", corner_valid, 1);
        check("f3_scale_kept", scale_out, 8'h33);
        check("f3_no_pops", got_x.size(), 0);
        hx = int'(corner_x); hy = int'(corner_y); changes = 0;
        repeat (10) begin
            idle(1, 1'b1);
            if (int'(corner_x) != hx || int'(corner_y) != hy || !corner_valid) changes++;
        end
        check("f3_hold_changes", changes, 0);
        check("f3_head_x", hx, 2);
        check("f3_head_y", hy, 2);
        drain();
        check_pops("f3", 0, 16);
        check("f3_empty", corner_valid, 0);

        // Frame 4: fill to 16, then a corner arrives in the same cycle as a pop.
        threshold = 52'sh4000000000000; hi_v = threshold + 52'sd1; lo_v = threshold;
        tbl.delete();
        for (int c = 10; c <= 26; c++) tbl.push_back('{c, 20, 1'b1, c == 26});
        run_frame(8'h44, -1);
        check("f4_inframe_pops", got_x.size(), 1);
        check("f4_first_x", got_x.size() > 0 ? got_x[0] : -1, 8);
        check("f4_first_y", got_y.size() > 0 ? got_y[0] : -1, 18);
        check("f4_count", corner_count, 17);
        check("f4_overflow", overflow, 0);
        check("f4_valid", corner_valid, 1);
        drain();
        check_pops("f4", 1, 16);
        check("f4_empty", corner_valid, 0);

        // Frame 5: reset at row 20 with one corner queued; start must be given again.
        threshold = 52'sd1000; hi_v = 52'sd1001; lo_v = 52'sd1000;
        tbl.delete();
        tbl.push_back('{30, 10, 1'b1, 1'b0});
        d0 = done_cnt;
        run_frame(8'h55, 20);
        check("f5_busy_pre", busy, 1);
        check("f5_count_pre", corner_count, 1);
        reset = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        reset = 1'b1;
        check("f5_busy", busy, 0);
        check("f5_valid", corner_valid, 0);
        check("f5_count", corner_count, 0);
        check("f5_overflow", overflow, 0);
        check("f5_scale", scale_out, 0);
        check("f5_done", done, 0);
        shift_cnt = 0; busy_seen = 0;
        for (int r = 0; r < 6; r++) begin
            if (r == 3) begin
                idle(3, 1'b0);
                idle(3, 1'b1);
            end
            for (int c = 0; c < LINE_LEN; c++) cycle(1'b1, 1'b1, 1'b0, 1'b0, c, r);
            idle(HBLANK, 1'b1);
        end
        check("f5_shift_after", shift_cnt, 0);
        check("f5_busy_after", busy_seen, 0);
        check("f5_no_done", done_cnt - d0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
